z80vram_arbiter: RTL and testbench

//   Memory-side responder for the ZX video scanner. Answers its video_addr with video_data from a

---
 rtl/z80vram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_z80vram_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80vram_arbiter.sv
// Single-port VRAM arbiter for the ZX video scanner and the Z80: video fetches first,
// then posted CPU writes, then CPU reads. Also holds the border colour register.
module z80vram_arbiter #(
  parameter int         VRAM_SIZE    = 6912,
  parameter logic [2:0] BORDER_RESET = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] video_addr,
  output logic [7:0]  video_data,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        io_wr,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_wdata,
  output logic [2:0]  border
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE
  } rd_state_t;

  rd_state_t state, state_nxt;

  logic [12:0] vtag;
  logic        vtag_valid;
  logic        vpend;
  logic [7:0]  vhold;

  logic        wb_valid;
  logic [12:0] wb_addr;
  logic [7:0]  wb_data;

  logic vmiss;
  logic wb_drain;
  logic cpu_is_wr;
  logic cpu_is_rd;
  logic cpu_in_range;
  logic wr_ack;
  logic wr_post;
  logic rd_issue;
  logic rd_oor;
  logic io_unused;

  function automatic logic in_range(input logic [12:0] a);
    return ({1'b0, a} < 14'(VRAM_SIZE));
  endfunction

  assign io_unused = ^{io_addr[7:1], io_wdata[7:3]};

  assign vmiss        = !vtag_valid || (video_addr != vtag);
  assign wb_drain     = wb_valid && !vmiss;
  assign cpu_in_range = in_range(cpu_addr);

  // A simultaneous rd+wr is handled as a write; new requests only start from IDLE.
  assign cpu_is_wr = cpu_wr && (state == IDLE);
  assign cpu_is_rd = cpu_rd && !cpu_wr && (state == IDLE);

  assign wr_ack   = cpu_is_wr && (!cpu_in_range || !wb_valid || wb_drain);
  assign wr_post  = wr_ack && cpu_in_range;
  assign rd_oor   = cpu_is_rd && !cpu_in_range;
  assign rd_issue = cpu_is_rd && cpu_in_range && !vmiss && !wb_valid;

  always_comb begin
    mem_addr  = video_addr;
    mem_wdata = wb_data;
    mem_we    = 1'b0;
    if (!vmiss) begin
      if (wb_valid) begin
        mem_addr = wb_addr;
        mem_we   = 1'b1;
      end else if (rd_issue) begin
        mem_addr = cpu_addr;
      end
    end
  end

  // Fresh fetch is bypassed straight from the RAM, otherwise replay the held byte.
  assign video_data = vpend ? mem_rdata : vhold;

  always_comb begin
    state_nxt = state;
    cpu_ready = wr_ack;
    case (state)
      IDLE: begin
        if (rd_oor) begin
          state_nxt = RD_DONE;
        end else if (rd_issue) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = RD_DONE;
      RD_DONE: begin
        state_nxt = IDLE;
        cpu_ready = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= 8'h00;
    end else if (state == RD_WAIT) begin
      cpu_rdata <= mem_rdata;
    end else if (rd_oor) begin
      cpu_rdata <= 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtag_valid <= 1'b0;
      vpend      <= 1'b0;
      vhold      <= 8'h00;
    end else begin
      vpend <= vmiss;
      if (vmiss) begin
        vtag_valid <= 1'b1;
      end else if (wb_drain && (wb_addr == vtag)) begin
        // Drained write hit the displayed byte: force the scanner to refetch it.
        vtag_valid <= 1'b0;
      end
      if (vpend) begin
        vhold <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vmiss) begin
      vtag <= video_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (wr_post) begin
      wb_valid <= 1'b1;
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_post) begin
      wb_addr <= cpu_addr;
      wb_data <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      border <= BORDER_RESET;
    end else if (io_wr && !io_addr[0]) begin
      border <= io_wdata[2:0];
    end
  end

endmodule

// File: tb/tb_z80vram_arbiter.sv
// Bench for z80vram_arbiter: directed scenarios plus random CPU/video/IO traffic,
// checked by a queue scoreboard against a flat shadow-memory model.
module tb_z80vram_arbiter;
  localparam int VRAM_SIZE = 6912;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] video_addr;
  logic [7:0]  video_data;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        io_wr;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [2:0]  border;

  always #5 clk = ~clk;

  z80vram_arbiter #(
    .VRAM_SIZE   (VRAM_SIZE),
    .BORDER_RESET(3'b000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .video_addr(video_addr),
    .video_data(video_data),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .border    (border)
  );

  // Power-on RAM contents, known to both the RAM model and the reference.
  function automatic logic [7:0] init_byte(input logic [12:0] a);
    logic [12:0] t;
    if (a == 13'h0000) return 8'hA5;
    if (a == 13'h0100) return 8'h3C;
    t = a * 13'd7 + (a >> 8);
    return t[7:0] ^ 8'h5B;
  endfunction

  logic [7:0] ram [0:8191];
  bit         ram_written [0:8191];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]         <= mem_wdata;
      ram_written[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_written[mem_addr] ? ram[mem_addr] : init_byte(mem_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: CPU-visible memory after every acknowledged write.
  logic [7:0]  ref_mem [int];
  logic [20:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int          last_wr [0:8191];
  int          vchg_cyc = 0;
  bit          rnd_video = 1'b0;
  bit          vid_chk_en = 1'b0;
  logic [2:0]  border_exp = 3'b000;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cpu_ready && cpu_rd && !cpu_wr) begin
          chk("rd_expected", 32'(rd_q.size() > 0), 1);
          if (rd_q.size() > 0) chk("rd_data", 32'(cpu_rdata), 32'(rd_q.pop_front()));
        end
        if (mem_we) begin
          chk("wr_expected", 32'(wr_q.size() > 0), 1);
          if (wr_q.size() > 0) begin
            logic [20:0] e;
            e = wr_q.pop_front();
            chk("drain_addr", 32'(mem_addr), 32'(e[20:8]));
            chk("drain_data", 32'(mem_wdata), 32'(e[7:0]));
          end
        end
        if (vid_chk_en && (cyc - vchg_cyc >= 2) && (cyc - last_wr[video_addr] >= 6))
          chk("video_data", 32'(video_data), 32'(ref_rd(video_addr)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_video && (cyc % 12 == 0)) begin
      video_addr = $urandom_range(0, 1) ? 13'($urandom_range(0, 31))
                                        : 13'($urandom_range(0, VRAM_SIZE - 1));
      vchg_cyc = cyc;
    end
  endtask

  task automatic wr_accepted(input logic [12:0] a, input logic [7:0] d);
    if (int'(a) < VRAM_SIZE) begin
      ref_mem[int'(a)] = d;
      wr_q.push_back({a, d});
      last_wr[a] = cyc;
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d, output int lat);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_wr = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (cpu_ready) begin
        wr_accepted(a, d);
        break;
      end
      lat++;
      if (lat > 30) begin
        chk("wr_ack_timeout", 32'(cpu_ready), 1);
        break;
      end
      step();
    end
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic do_read(input logic [12:0] a, output int lat);
    rd_q.push_back((int'(a) < VRAM_SIZE) ? ref_rd(a) : 8'hFF);
    cpu_addr = a;
    cpu_rd = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (cpu_ready) break;
      lat++;
      if (lat > 30) begin
        chk("rd_ready_timeout", 32'(cpu_ready), 1);
        break;
      end
      step();
    end
    step();
    cpu_rd = 1'b0;
  endtask

  task automatic do_io(input logic [7:0] p, input logic [7:0] d);
    io_addr = p;
    io_wdata = d;
    io_wr = 1'b1;
    if (!p[0]) border_exp = d[2:0];
    step();
    io_wr = 1'b0;
    @(negedge clk);
    chk("border", 32'(border), 32'(border_exp));
    step();
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 8192; i++) last_wr[i] = -100;
    reset = 1'b1;
    video_addr = 13'h0000;
    cpu_addr = 13'h0000;
    cpu_wdata = 8'h00;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    io_wr = 1'b0;
    io_addr = 8'h00;
    io_wdata = 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("rst_video_data", 32'(video_data), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_border", 32'(border), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);

    // Video fetch of address 0 after reset.
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_miss_addr", 32'(mem_addr), 0);
    chk("t1_miss_we", 32'(mem_we), 0);
    step();
    @(negedge clk);
    chk("t1_video_data", 32'(video_data), 32'h A5);
    repeat (3) step();
    @(negedge clk);
    chk("t1_video_hold", 32'(video_data), 32'h A5);

    // Posted write, second write accepted while the first drains.
    step();
    cpu_addr = 13'h1800;
    cpu_wdata = 8'h47;
    cpu_wr = 1'b1;
    @(negedge clk);
    chk("t2_ack_same_cycle", 32'(cpu_ready), 1);
    wr_accepted(13'h1800, 8'h47);
    step();
    cpu_addr = 13'h1801;
    cpu_wdata = 8'h99;
    @(negedge clk);
    chk("t2_drain_we", 32'(mem_we), 1);
    chk("t2_drain_addr", 32'(mem_addr), 32'h1800);
    chk("t2_drain_wdata", 32'(mem_wdata), 32'h47);
    chk("t2_ack_in_drain", 32'(cpu_ready), 1);
    wr_accepted(13'h1801, 8'h99);
    step();
    cpu_wr = 1'b0;
    @(negedge clk);
    chk("t2_drain2_addr", 32'(mem_addr), 32'h1801);

    // Video miss collides with a pending drain.
    step();
    cpu_addr = 13'h0200;
    cpu_wdata = 8'h33;
    cpu_wr = 1'b1;
    @(negedge clk);
    chk("t3_ack", 32'(cpu_ready), 1);
    wr_accepted(13'h0200, 8'h33);
    step();
    cpu_wr = 1'b0;
    video_addr = 13'h0005;
    @(negedge clk);
    chk("t3_video_wins_we", 32'(mem_we), 0);
    chk("t3_video_wins_addr", 32'(mem_addr), 5);
    step();
    @(negedge clk);
    chk("t3_late_drain_we", 32'(mem_we), 1);
    chk("t3_late_drain_addr", 32'(mem_addr), 32'h0200);
    chk("t3_video_data", 32'(video_data), 32'(ref_rd(13'h0005)));

    // CPU reads: uncontended latency, then read-after-write.
    step();
    do_read(13'h0100, lat);
    chk("t4_rd_latency", 32'(lat), 2);
    do_write(13'h0100, 8'hC7, lat);
    do_read(13'h0100, lat);

    // Out-of-range accesses and border register.
    do_write(13'h1B00, 8'h5A, lat);
    chk("t5_oor_wr_ack", 32'(lat), 0);
    do_read(13'h1FFF, lat);
    chk("t5_oor_rd_latency", 32'(lat), 1);
    do_io(8'hFE, 8'h05);
    do_io(8'hFF, 8'h02);

    // Write to the displayed byte forces a refetch.
    video_addr = 13'h0000;
    step();
    step();
    @(negedge clk);
    chk("t6_video_before", 32'(video_data), 32'h A5);
    step();
    do_write(13'h0000, 8'h11, lat);
    @(negedge clk);
    chk("t6_drain_we", 32'(mem_we), 1);
    chk("t6_drain_addr", 32'(mem_addr), 0);
    step();
    step();
    @(negedge clk);
    chk("t6_video_refetch", 32'(video_data), 32'h11);
    step();

    // Reset while the write buffer holds an entry: entry must be dropped.
    cpu_addr = 13'h0010;
    cpu_wdata = 8'h77;
    cpu_wr = 1'b1;
    @(negedge clk);
    chk("t6_wb_fill_ack", 32'(cpu_ready), 1);
    step();
    cpu_wr = 1'b0;
    reset = 1'b1;
    border_exp = 3'b000;
    @(negedge clk);
    chk("t6_rst_mem_we", 32'(mem_we), 0);
    chk("t6_rst_border", 32'(border), 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_post_rst_we", 32'(mem_we), 0);
      step();
    end

    // Random traffic.
    rnd_video = 1'b1;
    vid_chk_en = 1'b1;
    vchg_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [12:0] a;
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 1) ? 13'($urandom_range(0, 31)) : 13'($urandom_range(0, VRAM_SIZE - 1));
      if (r < 40) do_write(a, 8'($urandom), lat);
      else if (r < 80) do_read(a, lat);
      else if (r < 87) do_write(13'($urandom_range(VRAM_SIZE, 8191)), 8'($urandom), lat);
      else if (r < 94) do_read(13'($urandom_range(VRAM_SIZE, 8191)), lat);
      else do_io(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_video = 1'b0;
    repeat (10) step();
    vid_chk_en = 1'b0;
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
